// File: rtl/response_router_if.sv
// response_router_if
//   Bundles the port-side response bus and the consumer-side FIFO bus of the
//   response router.
//   master : producer/consumer environment (drives k_valid/k_data/k_pivot and
//            c_ready, observes everything else)
//   slave  : the router itself
//   Ports of the bundle:
//     k_valid[NKERNELS]            port k presents a response
//     k_data[NKERNELS][RES_WIDTH]  response word
//     k_pivot[NKERNELS][CW]        destination consumer id
//     k_ready[NKERNELS]            response from port k accepted this cycle
//     c_valid[NCONSUMERS]          consumer FIFO non-empty
//     c_data[NCONSUMERS][RES_WIDTH] FIFO head, 0 when empty
//     c_ready[NCONSUMERS]          consumer pops head
//     c_level[NCONSUMERS][LW]      FIFO occupancy
//     collision_cnt[16]            saturating count of contended cycles
//     err_bad_pivot                sticky out-of-range pivot flag
interface response_router_if #(
  parameter int RES_WIDTH  = 20,
  parameter int NKERNELS   = 4,
  parameter int NCONSUMERS = 8,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(NCONSUMERS);
  localparam int LW = $clog2(DEPTH + 1);

  logic [NKERNELS-1:0]                  k_valid;
  logic [NKERNELS-1:0][RES_WIDTH-1:0]   k_data;
  logic [NKERNELS-1:0][CW-1:0]          k_pivot;
  logic [NKERNELS-1:0]                  k_ready;
  logic [NCONSUMERS-1:0]                c_valid;
  logic [NCONSUMERS-1:0][RES_WIDTH-1:0] c_data;
  logic [NCONSUMERS-1:0]                c_ready;
  logic [NCONSUMERS-1:0][LW-1:0]        c_level;
  logic [15:0]                          collision_cnt;
  logic                                 err_bad_pivot;

  modport master (
    output k_valid, k_data, k_pivot, c_ready,
    input  k_ready, c_valid, c_data, c_level, collision_cnt, err_bad_pivot
  );

  modport slave (
    input  k_valid, k_data, k_pivot, c_ready,
    output k_ready, c_valid, c_data, c_level, collision_cnt, err_bad_pivot
  );
endinterface

// File: rtl/response_router.sv
// response_router
//   Routes responses from NKERNELS PLM ports to NCONSUMERS consumers. Each
//   consumer owns a round-robin arbiter and a DEPTH-entry FIFO, so ports that
//   collide on one consumer in the same cycle are stalled (k_ready low) rather
//   than corrupting the output.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - response_router_if.slave (port side k_*, consumer side c_*,
//            collision_cnt, err_bad_pivot)
module response_router #(
  parameter int RES_WIDTH  = 20,
  parameter int NKERNELS   = 4,
  parameter int NCONSUMERS = 8,
  parameter int DEPTH      = 2
) (
  input  logic              clk,
  input  logic              rst,
  response_router_if.slave  bus
);
  localparam int KW = $clog2(NKERNELS);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [NCONSUMERS-1:0][NKERNELS-1:0]  req;
  logic [NCONSUMERS-1:0][NKERNELS-1:0]  gnt;
  logic [NCONSUMERS-1:0][KW-1:0]        gnt_idx;
  logic [NCONSUMERS-1:0]                push;
  logic [NCONSUMERS-1:0]                pop;
  logic [NCONSUMERS-1:0][RES_WIDTH-1:0] push_data;
  logic [NKERNELS-1:0]                  bad;
  logic                                 any_collision;

  logic [NCONSUMERS-1:0][KW-1:0]        rr;
  logic [NCONSUMERS-1:0][AW-1:0]        wr_ptr;
  logic [NCONSUMERS-1:0][AW-1:0]        rd_ptr;
  logic [NCONSUMERS-1:0][LW-1:0]        level;
  logic [RES_WIDTH-1:0]                 mem [NCONSUMERS][DEPTH];
  logic [15:0]                          collision_q;
  logic                                 err_q;

  // Request decode, collision detection and per-consumer round-robin grant.
  // A full FIFO issues no grant even if it is being popped this cycle, which
  // keeps k_ready independent of c_ready.
  always_comb begin
    int idx;
    logic [KW-1:0] kk;
    idx = 0;
    kk = '0;
    any_collision = 1'b0;
    for (int k = 0; k < NKERNELS; k++) begin
      bad[k] = bus.k_valid[k] && (int'(bus.k_pivot[k]) >= NCONSUMERS);
    end
    for (int c = 0; c < NCONSUMERS; c++) begin
      for (int k = 0; k < NKERNELS; k++) begin
        req[c][k] = bus.k_valid[k] && (int'(bus.k_pivot[k]) == c);
      end
      // More than one bit set means contention on this consumer.
      if ((req[c] & (req[c] - NKERNELS'(1))) != '0) begin
        any_collision = 1'b1;
      end
      gnt[c]     = '0;
      gnt_idx[c] = '0;
      push[c]    = 1'b0;
      if (level[c] < LW'(DEPTH)) begin
        for (int i = 0; i < NKERNELS; i++) begin
          idx = int'(rr[c]) + i;
          if (idx >= NKERNELS) begin
            idx = idx - NKERNELS;
          end
          kk = KW'(idx);
          if (!push[c] && req[c][kk]) begin
            push[c]    = 1'b1;
            gnt[c][kk] = 1'b1;
            gnt_idx[c] = kk;
          end
        end
      end
      push_data[c] = bus.k_data[gnt_idx[c]];
      pop[c]       = (level[c] != '0) && bus.c_ready[c];
    end
  end

  // A port is accepted when it wins its consumer, or unconditionally when its
  // pivot is out of range (the word is then dropped).
  always_comb begin
    bus.k_ready = bad;
    for (int k = 0; k < NKERNELS; k++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (gnt[c][k]) begin
          bus.k_ready[k] = 1'b1;
        end
      end
    end
  end

  // FIFO pointers, occupancy, arbiter pointers and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      collision_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + AW'(1);
          rr[c]     <= (int'(gnt_idx[c]) == NKERNELS - 1) ? '0 : gnt_idx[c] + KW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + AW'(1);
        end
        if (push[c] && !pop[c]) begin
          level[c] <= level[c] + LW'(1);
        end else if (!push[c] && pop[c]) begin
          level[c] <= level[c] - LW'(1);
        end
      end
      if (any_collision && (collision_q != 16'hFFFF)) begin
        collision_q <= collision_q + 16'd1;
      end
      if (bad != '0) begin
        err_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because empty FIFOs present 0.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= push_data[c];
      end
    end
  end

  // Consumer-side outputs are derived from registered state only.
  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      bus.c_level[c] = level[c];
      bus.c_valid[c] = (level[c] != '0);
      bus.c_data[c]  = (level[c] != '0) ? mem[c][rd_ptr[c]] : '0;
    end
    bus.collision_cnt = collision_q;
    bus.err_bad_pivot = err_q;
  end
endmodule

// File: tb/tb_response_router.sv
// tb_response_router
//   Directed bench for response_router with NKERNELS=4, NCONSUMERS=6, DEPTH=2.
//   Inputs change on the falling edge; combinational k_ready is sampled 1ns
//   later, registered outputs 1ns after the rising edge.
module tb_response_router;
  localparam int RES_WIDTH  = 20;
  localparam int NKERNELS   = 4;
  localparam int NCONSUMERS = 6;
  localparam int DEPTH      = 2;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  response_router_if #(
    .RES_WIDTH(RES_WIDTH), .NKERNELS(NKERNELS),
    .NCONSUMERS(NCONSUMERS), .DEPTH(DEPTH)
  ) bus ();

  response_router #(
    .RES_WIDTH(RES_WIDTH), .NKERNELS(NKERNELS),
    .NCONSUMERS(NCONSUMERS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One collision-table row: stimulus plus hand-computed results.
  typedef struct {
    logic [3:0][19:0] dat;
    logic [3:0]       exp_ready;
    logic [5:0]       exp_cvalid;
    logic [19:0]      exp_c4;
    logic [15:0]      exp_cnt;
  } vec_t;

  vec_t vecs [6];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] kv, input logic [3:0][2:0] piv,
                                input logic [3:0][19:0] dat, input logic [5:0] cr);
    @(negedge clk);
    bus.k_valid = kv;
    bus.k_pivot = piv;
    bus.k_data  = dat;
    bus.c_ready = cr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.k_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    logic [3:0][2:0]  piv;
    logic [3:0][19:0] dat;
    logic [5:0]       mask;
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    bus.k_valid  = '0;
    bus.k_pivot  = '0;
    bus.k_data   = '0;
    bus.c_ready  = '0;

    vecs[0] = '{dat: '{20'h10003, 20'h0, 20'h10001, 20'h10000}, exp_ready: 4'b0001, exp_cvalid: 6'b010000, exp_c4: 20'h10000, exp_cnt: 16'd1};
    vecs[1] = '{dat: '{20'h20003, 20'h0, 20'h20001, 20'h20000}, exp_ready: 4'b0010, exp_cvalid: 6'b010000, exp_c4: 20'h20001, exp_cnt: 16'd2};
    vecs[2] = '{dat: '{20'h30003, 20'h0, 20'h30001, 20'h30000}, exp_ready: 4'b1000, exp_cvalid: 6'b010000, exp_c4: 20'h30003, exp_cnt: 16'd3};
    vecs[3] = '{dat: '{20'h40003, 20'h0, 20'h40001, 20'h40000}, exp_ready: 4'b0001, exp_cvalid: 6'b010000, exp_c4: 20'h40000, exp_cnt: 16'd4};
    vecs[4] = '{dat: '{20'h50003, 20'h0, 20'h50001, 20'h50000}, exp_ready: 4'b0010, exp_cvalid: 6'b010000, exp_c4: 20'h50001, exp_cnt: 16'd5};
    vecs[5] = '{dat: '{20'h60003, 20'h0, 20'h60001, 20'h60000}, exp_ready: 4'b1000, exp_cvalid: 6'b010000, exp_c4: 20'h60003, exp_cnt: 16'd6};

    // Reset state.
    #12;
    check_output("rst_c_valid", 64'(bus.c_valid), 64'h0);
    check_output("rst_c_level", 64'(bus.c_level), 64'h0);
    check_output("rst_c_data", 64'(bus.c_data), 64'h0);
    check_output("rst_cnt", 64'(bus.collision_cnt), 64'h0);
    check_output("rst_err", 64'(bus.err_bad_pivot), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single route: port 2 to consumer 5.
    $display("[TB] single route");
    piv = '0; piv[2] = 3'd5;
    dat = '0; dat[2] = 20'h0ABCD;
    apply_stimulus(4'b0100, piv, dat, 6'b100000);
    check_output("single_k_ready", 64'(bus.k_ready), 64'h4);
    check_output("single_no_early_valid", 64'(bus.c_valid), 64'h0);
    tick();
    check_output("single_c_valid", 64'(bus.c_valid), 64'h20);
    check_output("single_c_data5", 64'(bus.c_data[5]), 64'h0ABCD);
    check_output("single_c_level5", 64'(bus.c_level[5]), 64'h1);
    apply_stimulus(4'b0000, piv, dat, 6'b100000);
    tick();
    check_output("single_drained", 64'(bus.c_valid), 64'h0);

    // Collision on consumer 4 from ports 0, 1 and 3.
    $display("[TB] collision round-robin");
    piv = '0; piv[0] = 3'd4; piv[1] = 3'd4; piv[3] = 3'd4;
    for (int r = 0; r < 6; r++) begin
      apply_stimulus(4'b1011, piv, vecs[r].dat, 6'b111111);
      check_output($sformatf("coll_k_ready_r%0d", r), 64'(bus.k_ready), 64'(vecs[r].exp_ready));
      tick();
      check_output($sformatf("coll_c_valid_r%0d", r), 64'(bus.c_valid), 64'(vecs[r].exp_cvalid));
      check_output($sformatf("coll_c_data4_r%0d", r), 64'(bus.c_data[4]), 64'(vecs[r].exp_c4));
      check_output($sformatf("coll_cnt_r%0d", r), 64'(bus.collision_cnt), 64'(vecs[r].exp_cnt));
    end
    apply_stimulus(4'b0000, piv, '0, 6'b111111);
    tick();
    check_output("coll_drained", 64'(bus.c_valid), 64'h0);
    check_output("coll_cnt_hold", 64'(bus.collision_cnt), 64'd6);

    // Parallel disjoint routes; reset first so collision_cnt starts at 0.
    $display("[TB] parallel routes");
    pulse_reset();
    check_output("par_cnt_reset", 64'(bus.collision_cnt), 64'h0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      mask = '0;
      for (int k = 0; k < 4; k++) begin
        piv[k] = 3'((k + cyc) % 6);
        dat[k] = 20'h50000 | 20'((cyc << 4) | k);
        mask[(k + cyc) % 6] = 1'b1;
      end
      apply_stimulus(4'b1111, piv, dat, 6'b111111);
      check_output($sformatf("par_k_ready_c%0d", cyc), 64'(bus.k_ready), 64'hF);
      tick();
      check_output($sformatf("par_c_valid_c%0d", cyc), 64'(bus.c_valid), 64'(mask));
      for (int k = 0; k < 4; k++) begin
        check_output($sformatf("par_data_c%0d_k%0d", cyc, k), 64'(bus.c_data[piv[k]]), 64'(dat[k]));
      end
      check_output($sformatf("par_cnt_c%0d", cyc), 64'(bus.collision_cnt), 64'h0);
    end

    // Backpressure on consumer 1 from port 0.
    $display("[TB] backpressure");
    piv = '0; piv[0] = 3'd1;
    dat = '0; dat[0] = 20'hB0000;
    apply_stimulus(4'b0001, piv, dat, 6'b111101);
    check_output("bp_w0_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("bp_w0_level", 64'(bus.c_level[1]), 64'h1);
    dat[0] = 20'hB0001;
    apply_stimulus(4'b0001, piv, dat, 6'b111101);
    check_output("bp_w1_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("bp_w1_level", 64'(bus.c_level[1]), 64'h2);
    check_output("bp_head_w0", 64'(bus.c_data[1]), 64'hB0000);
    dat[0] = 20'hB0002;
    apply_stimulus(4'b0001, piv, dat, 6'b111101);
    check_output("bp_w2_stall1", 64'(bus.k_ready), 64'h0);
    tick();
    apply_stimulus(4'b0001, piv, dat, 6'b111101);
    check_output("bp_w2_stall2", 64'(bus.k_ready), 64'h0);
    tick();
    check_output("bp_full_level", 64'(bus.c_level[1]), 64'h2);
    apply_stimulus(4'b0001, piv, dat, 6'b111111);
    check_output("bp_pop_no_push", 64'(bus.k_ready), 64'h0);
    tick();
    check_output("bp_after_pop_level", 64'(bus.c_level[1]), 64'h1);
    check_output("bp_head_w1", 64'(bus.c_data[1]), 64'hB0001);
    apply_stimulus(4'b0001, piv, dat, 6'b111101);
    check_output("bp_w2_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("bp_w2_level", 64'(bus.c_level[1]), 64'h2);
    apply_stimulus(4'b0000, piv, dat, 6'b111111);
    tick();
    check_output("bp_head_w2", 64'(bus.c_data[1]), 64'hB0002);
    tick();
    check_output("bp_empty_valid", 64'(bus.c_valid[1]), 64'h0);
    check_output("bp_empty_data", 64'(bus.c_data[1]), 64'h0);

    // Out-of-range pivot.
    $display("[TB] bad pivot");
    piv = '0; piv[0] = 3'd7;
    dat = '0; dat[0] = 20'hDEAD0;
    apply_stimulus(4'b0001, piv, dat, 6'b111111);
    check_output("bad_k_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("bad_no_valid", 64'(bus.c_valid), 64'h0);
    check_output("bad_err_set", 64'(bus.err_bad_pivot), 64'h1);
    apply_stimulus(4'b0000, piv, dat, 6'b111111);
    tick();
    tick();
    check_output("bad_err_sticky", 64'(bus.err_bad_pivot), 64'h1);

    // Async reset while FIFOs hold data.
    $display("[TB] async reset mid-stream");
    piv = '{3'd3, 3'd2, 3'd1, 3'd0};
    dat = '{20'hA0003, 20'hA0002, 20'hA0001, 20'hA0000};
    apply_stimulus(4'b1111, piv, dat, 6'b000000);
    check_output("ar_load_ready", 64'(bus.k_ready), 64'hF);
    tick();
    apply_stimulus(4'b1111, piv, dat, 6'b000000);
    tick();
    check_output("ar_level0_full", 64'(bus.c_level[0]), 64'h2);
    piv = '0; piv[0] = 3'd4; piv[1] = 3'd4;
    apply_stimulus(4'b0011, piv, dat, 6'b000000);
    check_output("ar_coll_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("ar_cnt_pre", 64'(bus.collision_cnt), 64'h1);
    @(negedge clk);
    bus.k_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    check_output("ar_c_valid", 64'(bus.c_valid), 64'h0);
    check_output("ar_c_level", 64'(bus.c_level), 64'h0);
    check_output("ar_cnt", 64'(bus.collision_cnt), 64'h0);
    check_output("ar_err", 64'(bus.err_bad_pivot), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    piv = '0;
    dat = '0; dat[0] = 20'hC0000; dat[2] = 20'hC0002;
    apply_stimulus(4'b0101, piv, dat, 6'b111111);
    check_output("ar_rr_reset_ready", 64'(bus.k_ready), 64'h1);
    tick();
    check_output("ar_post_valid", 64'(bus.c_valid), 64'h1);
    check_output("ar_post_data", 64'(bus.c_data[0]), 64'hC0000);
    check_output("ar_post_cnt", 64'(bus.collision_cnt), 64'h1);
    apply_stimulus(4'b0000, piv, dat, 6'b111111);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
